pushbutton_debounce_bank: RTL and testbench
===========================================

// Module: pushbutton_debounce_bank
// PURPOSE
//  Parametrised N-channel push-button conditioner. It replaces the per-button
//  debouncer instances in the board top level.
//  - Synchronises raw board buttons into the clk_27 domain.
//  - Filters contact bounce with a per-channel stable-time counter.
//  - Emits a debounced level plus one-cycle press/release pulses per channel.
//  - Feeds the processor step/run/reset/display controls.
// PARAMETERS
//  NUM_BTN          4      number of independent button channels (>=1)
//  DEBOUNCE_CYCLES  65536  consecutive stable cycles required to accept a change (>=2)
//  ACTIVE_LOW_IN    1      1: raw input low = pressed (board keys); 0: high = pressed
//  REPEAT_DELAY     13500000  hold cycles before first auto-repeat (macro only)
//  REPEAT_PERIOD    2700000   cycles between auto-repeat pulses (macro only)
// PORTS
//  clk_27       in   1        system clock, all logic on rising edge
//  reset_n      in   1        asynchronous active-low reset
//  btn_raw      in   NUM_BTN  unsynchronised board button pins
//  btn_state    out  NUM_BTN  debounced level, 1 = pressed
//  btn_press    out  NUM_BTN  1-cycle pulse on accepted press (and repeats, see macro)
//  btn_release  out  NUM_BTN  1-cycle pulse on accepted release
//  any_pressed  out  1        OR of btn_state
// BEHAVIOUR
//  - Reset (async assert, sync release by clocking):
//    - sync flops take the inactive raw level (1 if ACTIVE_LOW_IN, else 0).
//    - counters = 0; btn_state/btn_press/btn_release/any_pressed = 0.
//  - Input path: 2-flop synchroniser per channel, then polarity normalise to
//    pressed=1 -> s[i].
//  - Per-channel counter, width $clog2(DEBOUNCE_CYCLES):
//    - s[i]==btn_state[i]: counter cleared to 0.
//    - s[i]!=btn_state[i]: counter increments.
//    - Counter at DEBOUNCE_CYCLES-1 with mismatch still present: the next edge
//      toggles btn_state[i], clears the counter, and asserts press (0->1) or
//      release (1->0) for exactly that one cycle.
//  - Latency: a raw edge held steady is reflected in btn_state exactly
//    2+DEBOUNCE_CYCLES clocks after the first sampling edge. Pulses are
//    coincident with the btn_state change.
//  - Glitch shorter than DEBOUNCE_CYCLES: counter restarts; no state change, no pulse.
//  - Channels are fully independent. Simultaneous accepted edges on several
//    channels pulse in the same cycle.
//  - Counter never wraps: it saturates by clearing on accept.
//  - Reset mid-count: all progress lost. The first post-reset press needs the
//    full 2+DEBOUNCE_CYCLES.
//  - any_pressed is combinational from the registered btn_state (no extra latency).
// CONFIGURATION
//  - DEBOUNCE_AUTOREPEAT_EN defined:
//    - Per channel, a hold counter runs while btn_state[i]=1.
//    - After REPEAT_DELAY cycles of hold, btn_press[i] pulses once.
//    - It then pulses every REPEAT_PERIOD cycles until release.
//    - Hold counter is cleared on release and on reset.
//    - Repeat pulses never coincide with btn_release.
//  - Undefined:
//    - btn_press pulses exactly once per accepted press.
//    - No hold counters are synthesised; REPEAT_* parameters are ignored.
// TESTING (DEBOUNCE_CYCLES=8, NUM_BTN=4, ACTIVE_LOW_IN=1)
//  - Reset: reset_n=0, btn_raw=4'hF -> all outputs 0; release reset, hold 20 clk
//    -> outputs stay 0.
//  - Clean press: btn_raw[0] 1->0 and held -> btn_state[0]=1 exactly 10 clk
//    later; btn_press[0] high 1 clk at that edge; any_pressed=1.
//  - Bounce: btn_raw[1] low 5 clk, high 2 clk, low held -> no pulse during
//    bounce; btn_state[1] rises 10 clk after final low edge; single btn_press[1].
//  - Release and simultaneous: ch2 and ch3 pressed same cycle -> both btn_press
//    pulse same cycle; both released same cycle -> both btn_release pulse once,
//    10 clk later.
//  - Reset mid-operation: btn_raw[0] low, reset_n pulsed low at count 5 -> state
//    stays 0; rises 10 clk after reset release.
//  - Macro on (REPEAT_DELAY=20, REPEAT_PERIOD=6): hold ch0 60 clk after accept
//    -> press pulses at accept, accept+20, +26, +32, ...; none after release.

Source files
------------

// File: rtl/pushbutton_debounce_bank.sv
// pushbutton_debounce_bank
//   N-channel push-button conditioner: 2-flop synchroniser, polarity
//   normalisation, per-channel stable-time debounce counter, registered
//   debounced level and one-cycle press/release pulses.
//   Optional feature macro: DEBOUNCE_AUTOREPEAT_EN adds hold-to-repeat press
//   pulses (REPEAT_DELAY / REPEAT_PERIOD exist only in that build).
module pushbutton_debounce_bank #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int ACTIVE_LOW_IN   = 1
`ifdef DEBOUNCE_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 13500000,
    parameter int REPEAT_PERIOD   = 2700000
`endif
) (
    input  logic               clk_27,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_state,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               any_pressed
);

    localparam int               CNT_W        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic             INACTIVE_LVL = (ACTIVE_LOW_IN != 0);

    logic [NUM_BTN-1:0] sync_p0;
    logic [NUM_BTN-1:0] sync_p1;
    logic [NUM_BTN-1:0] btn_norm;
    logic [NUM_BTN-1:0] mismatch;
    logic [NUM_BTN-1:0] accept;
    logic [CNT_W-1:0]   cnt [NUM_BTN];

    // Stable-time counter step: clears on agreement and on acceptance, so it never wraps
    function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] c,
                                                    input logic             m);
        if (!m || (c == CNT_MAX))
            return '0;
        return c + CNT_W'(1);
    endfunction

    // Two-flop synchroniser; idles at the released pin level so reset looks like "not pressed"
    always_ff @(posedge clk_27 or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= {NUM_BTN{INACTIVE_LVL}};
            sync_p1 <= {NUM_BTN{INACTIVE_LVL}};
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Normalise to pressed=1 and flag channels whose counter has run out while still disagreeing
    always_comb begin
        btn_norm = (ACTIVE_LOW_IN != 0) ? ~sync_p1 : sync_p1;
        mismatch = btn_norm ^ btn_state;
        accept   = '0;
        for (int i = 0; i < NUM_BTN; i++)
            accept[i] = mismatch[i] && (cnt[i] == CNT_MAX);
    end

    // Debounce counters, debounced level and release pulses
    always_ff @(posedge clk_27 or negedge reset_n) begin
        if (!reset_n) begin
            btn_state   <= '0;
            btn_release <= '0;
            for (int i = 0; i < NUM_BTN; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++)
                cnt[i] <= next_count(cnt[i], mismatch[i]);
            btn_state   <= btn_state ^ accept;
            btn_release <= accept & btn_state;
        end
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int                HOLD_W      = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [HOLD_W-1:0] hold_cnt [NUM_BTN];

    // Press pulse on accept, then repeats while held; reloading to DELAY-PERIOD spaces later repeats
    always_ff @(posedge clk_27 or negedge reset_n) begin
        if (!reset_n) begin
            btn_press <= '0;
            for (int i = 0; i < NUM_BTN; i++)
                hold_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                btn_press[i] <= 1'b0;
                if (accept[i] || !btn_state[i]) begin
                    // accepted press pulses; accepted release suppresses any repeat
                    btn_press[i] <= accept[i] && !btn_state[i];
                    hold_cnt[i]  <= '0;
                end else if (hold_cnt[i] == HOLD_LAST) begin
                    btn_press[i] <= 1'b1;
                    hold_cnt[i]  <= HOLD_RELOAD;
                end else begin
                    hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
                end
            end
        end
    end
`else
    // Press pulse exactly once per accepted press
    always_ff @(posedge clk_27 or negedge reset_n) begin
        if (!reset_n)
            btn_press <= '0;
        else
            btn_press <= accept & ~btn_state;
    end
`endif

    assign any_pressed = |btn_state;

endmodule

// File: tb/tb_pushbutton_debounce_bank.sv
// Testbench for pushbutton_debounce_bank (NUM_BTN=4, DEBOUNCE_CYCLES=8, active-low keys).
// Table-driven directed vectors, hand-written reset/auto-repeat sequences, and a
// randomized run against a history-based reference model.
module tb_pushbutton_debounce_bank;

    localparam int NB       = 4;
    localparam int DB       = 8;
    localparam int RAND_CYC = 1500;
`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int RD       = 20;
    localparam int RP       = 6;
`endif

    logic          clk_27 = 1'b0;
    logic          reset_n;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_state;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic          any_pressed;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_27 = ~clk_27;

    pushbutton_debounce_bank #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (DB),
        .ACTIVE_LOW_IN   (1)
`ifdef DEBOUNCE_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
`endif
    ) dut (
        .clk_27      (clk_27),
        .reset_n     (reset_n),
        .btn_raw     (btn_raw),
        .btn_state   (btn_state),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .any_pressed (any_pressed)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_all(input string name, input logic [NB-1:0] st,
                             input logic [NB-1:0] pr, input logic [NB-1:0] rl);
        check({name, ".state"},   32'(btn_state),   32'(st));
        check({name, ".press"},   32'(btn_press),   32'(pr));
        check({name, ".release"}, 32'(btn_release), 32'(rl));
        check({name, ".any"},     32'(any_pressed), 32'(|st));
    endtask

    // Directed vector table: apply raw, wait cycles, then expected outputs
    typedef struct {
        logic [NB-1:0] raw;
        int            wait_cyc;
        logic [NB-1:0] st;
        logic [NB-1:0] pr;
        logic [NB-1:0] rl;
    } vec_t;

    vec_t tbl [17];

    // Reference model state for the randomized run
    bit p_hist [NB][RAND_CYC];
    bit m_st   [NB];
    int m_lastT[NB];
    int m_accT [NB];

    function automatic bit get_p(input int ch, input int k);
        if (k < 0)
            return 1'b0;
        return p_hist[ch][k];
    endfunction

    task automatic do_reset(input logic [NB-1:0] raw_during);
        reset_n = 1'b0;
        btn_raw = raw_during;
        repeat (2) @(posedge clk_27);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int            now;
        int            acc_edge [NB];
        logic [NB-1:0] exp_pr;
        logic [NB-1:0] e_st, e_pr, e_rl;
        bit            tog;

        // clean press on ch0
        tbl[0]  = '{4'hE, 9, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'hE, 1, 4'b0001, 4'b0001, 4'b0000};
        tbl[2]  = '{4'hE, 1, 4'b0001, 4'b0000, 4'b0000};
        // bounce on ch1: low 5, high 2, then low held
        tbl[3]  = '{4'hC, 5, 4'b0001, 4'b0000, 4'b0000};
        tbl[4]  = '{4'hE, 2, 4'b0001, 4'b0000, 4'b0000};
        tbl[5]  = '{4'hC, 9, 4'b0001, 4'b0000, 4'b0000};
        tbl[6]  = '{4'hC, 1, 4'b0011, 4'b0010, 4'b0000};
        tbl[7]  = '{4'hC, 1, 4'b0011, 4'b0000, 4'b0000};
        // ch2+ch3 pressed together
        tbl[8]  = '{4'h0, 9, 4'b0011, 4'b0000, 4'b0000};
        tbl[9]  = '{4'h0, 1, 4'b1111, 4'b1100, 4'b0000};
        tbl[10] = '{4'h0, 1, 4'b1111, 4'b0000, 4'b0000};
        // ch2+ch3 released together
        tbl[11] = '{4'hC, 9, 4'b1111, 4'b0000, 4'b0000};
        tbl[12] = '{4'hC, 1, 4'b0011, 4'b0000, 4'b1100};
        tbl[13] = '{4'hC, 1, 4'b0011, 4'b0000, 4'b0000};
        // release everything
        tbl[14] = '{4'hF, 9, 4'b0011, 4'b0000, 4'b0000};
        tbl[15] = '{4'hF, 1, 4'b0000, 4'b0000, 4'b0011};
        tbl[16] = '{4'hF, 1, 4'b0000, 4'b0000, 4'b0000};

        // Reset behaviour
        reset_n = 1'b0;
        btn_raw = 4'hF;
        repeat (2) @(posedge clk_27);
        #1;
        check_all("reset", 4'b0, 4'b0, 4'b0);
        reset_n = 1'b1;
        repeat (20) @(posedge clk_27);
        #1;
        check_all("idle20", 4'b0, 4'b0, 4'b0);

        // Table-driven directed vectors
        now = 0;
        for (int c = 0; c < NB; c++) acc_edge[c] = 0;
        for (int i = 0; i < 17; i++) begin
            btn_raw = tbl[i].raw;
            repeat (tbl[i].wait_cyc) @(posedge clk_27);
            #1;
            now += tbl[i].wait_cyc;
            exp_pr = tbl[i].pr;
            for (int c = 0; c < NB; c++)
                if (tbl[i].pr[c]) acc_edge[c] = now;
`ifdef DEBOUNCE_AUTOREPEAT_EN
            for (int c = 0; c < NB; c++)
                if (tbl[i].st[c] && !tbl[i].pr[c] && (now - acc_edge[c] >= RD) &&
                    ((now - acc_edge[c] - RD) % RP == 0))
                    exp_pr[c] = 1'b1;
`endif
            check_all($sformatf("vec%0d", i), tbl[i].st, exp_pr, tbl[i].rl);
        end

        // Reset in the middle of a count: progress is lost
        btn_raw = 4'hE;
        repeat (7) @(posedge clk_27);
        #1;
        check_all("midcount", 4'b0, 4'b0, 4'b0);
        reset_n = 1'b0;
        #1;
        check_all("midreset", 4'b0, 4'b0, 4'b0);
        repeat (2) @(posedge clk_27);
        #1;
        reset_n = 1'b1;
        repeat (9) @(posedge clk_27);
        #1;
        check_all("postreset9", 4'b0, 4'b0, 4'b0);
        @(posedge clk_27);
        #1;
        check_all("postreset10", 4'b0001, 4'b0001, 4'b0);
        @(posedge clk_27);
        #1;
        check_all("postreset11", 4'b0001, 4'b0000, 4'b0);

`ifdef DEBOUNCE_AUTOREPEAT_EN
        // Auto-repeat: hold ch0 60 cycles after accept, then release
        do_reset(4'hF);
        btn_raw = 4'hE;
        repeat (10) @(posedge clk_27);
        #1;
        check_all("rep_accept", 4'b0001, 4'b0001, 4'b0);
        for (int k = 1; k <= 90; k++) begin
            @(posedge clk_27);
            #1;
            e_st = (k < 70) ? 4'b0001 : 4'b0000;
            e_pr = ((k < 70) && (k >= RD) && ((k - RD) % RP == 0)) ? 4'b0001 : 4'b0000;
            e_rl = (k == 70) ? 4'b0001 : 4'b0000;
            check_all($sformatf("rep_k%0d", k), e_st, e_pr, e_rl);
            if (k == 60) btn_raw = 4'hF;
        end
`endif

        // Randomized run against the reference model
        do_reset(4'hF);
        for (int c = 0; c < NB; c++) begin
            m_st[c]    = 1'b0;
            m_lastT[c] = -1;
            m_accT[c]  = -100000;
        end
        for (int t = 0; t < RAND_CYC; t++) begin
            @(negedge clk_27);
            for (int c = 0; c < NB; c++) begin
                if ($urandom_range(0, 11) == 0) btn_raw[c] = ~btn_raw[c];
                p_hist[c][t] = ~btn_raw[c];
            end
            @(posedge clk_27);
            #1;
            e_pr = '0;
            e_rl = '0;
            for (int c = 0; c < NB; c++) begin
                // accept when the last DB synchronised samples all disagreed with the level
                tog = (t - DB >= m_lastT[c]);
                for (int j = 1; j <= DB; j++)
                    if (get_p(c, t - 1 - j) == m_st[c]) tog = 1'b0;
                if (tog) begin
                    m_st[c]    = ~m_st[c];
                    m_lastT[c] = t;
                    if (m_st[c]) begin
                        e_pr[c]   = 1'b1;
                        m_accT[c] = t;
                    end else begin
                        e_rl[c] = 1'b1;
                    end
                end
`ifdef DEBOUNCE_AUTOREPEAT_EN
                else if (m_st[c] && (t - m_accT[c] >= RD) && ((t - m_accT[c] - RD) % RP == 0))
                    e_pr[c] = 1'b1;
`endif
            end
            for (int c = 0; c < NB; c++) e_st[c] = m_st[c];
            check_all($sformatf("rand%0d", t), e_st, e_pr, e_rl);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
